// File: rtl/vga_text_renderer.sv
// ---------------------------------------------------------------------------
// vga_text_renderer
//
// Three-stage pixel pipeline that sits behind the 1920x1080 VGA timing
// generator and turns its x/y stream into an 8x16-font text screen.
//
//   E1: compute the character RAM address and capture the pixel context.
//   E2: character word returns, so present {code, glyph line} to the font ROM.
//   E3: glyph row returns; select the pixel bit, apply blink/cursor, map
//       through the 16-entry palette and register RGB together with the
//       delayed syncs and active flag.
//
// Ports
//   i_clk, i_rst               pixel clock, synchronous active-high reset
//   i_x, i_y, i_active         pixel position and active-video flag
//   i_hs, i_vs                 syncs (active low), delayed 3 cycles to o_hs/o_vs
//   i_screenend                one-tick end-of-frame pulse, drives blink timing
//   i_cursor_col/row/en        hardware underline cursor
//   o_char_addr, i_char_data   character RAM (1-cycle read latency)
//   o_font_addr, i_font_data   font ROM (1-cycle read latency)
//   o_r, o_g, o_b              12-bit pixel colour
//   o_hs, o_vs, o_active       syncs/active aligned with RGB
//
// Handshake: there is none. The pipeline advances every clock; every input
// sampled at one edge has its pixel on the outputs three edges later.
// ---------------------------------------------------------------------------
module vga_text_renderer #(
  parameter int COLS              = 240,
  parameter int ROWS              = 67,
  parameter int BLINK_FRAMES      = 30,
  parameter int CURSOR_FIRST_LINE = 14
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_x,
  input  logic [10:0] i_y,
  input  logic        i_active,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_screenend,
  input  logic [7:0]  i_cursor_col,
  input  logic [6:0]  i_cursor_row,
  input  logic        i_cursor_en,
  output logic [13:0] o_char_addr,
  input  logic [15:0] i_char_data,
  output logic [11:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_active
);

  localparam logic [13:0] COLS_L       = 14'(COLS);
  localparam logic [6:0]  ROWS_L       = 7'(ROWS);
  localparam logic [3:0]  CURSOR_FL_L  = 4'(CURSOR_FIRST_LINE);
  localparam logic [7:0]  BLINK_LAST_L = 8'(BLINK_FRAMES - 1);

  // -------------------------------------------------------------------------
  // Blink timebase
  // -------------------------------------------------------------------------
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (i_screenend) begin
      if (blink_cnt_q == BLINK_LAST_L) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 (E1)
  // -------------------------------------------------------------------------
  logic [8:0]  col;
  logic [6:0]  row;
  logic [13:0] char_addr_d;
  logic        cursor_hit_d;

  assign col = i_x[11:3];
  assign row = i_y[10:4];

  // Row 67 (lines 1072-1079) still produces an address; it is never shown.
  assign char_addr_d  = 14'(row) * COLS_L + 14'(col);
  assign cursor_hit_d = i_cursor_en && (col == {1'b0, i_cursor_col}) &&
                        (row == i_cursor_row) && (i_y[3:0] >= CURSOR_FL_L);

  logic [13:0] char_addr_q;
  logic [2:0]  s1_xs_q;
  logic [3:0]  s1_line_q;
  logic        s1_act_q, s1_hs_q, s1_vs_q, s1_text_q, s1_cur_q, s1_ph_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      char_addr_q <= 14'd0;
      s1_xs_q     <= 3'd0;
      s1_line_q   <= 4'd0;
      s1_act_q    <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      s1_text_q   <= 1'b0;
      s1_cur_q    <= 1'b0;
      s1_ph_q     <= 1'b0;
    end else begin
      char_addr_q <= char_addr_d;
      s1_xs_q     <= i_x[2:0];
      s1_line_q   <= i_y[3:0];
      s1_act_q    <= i_active;
      s1_hs_q     <= i_hs;
      s1_vs_q     <= i_vs;
      s1_text_q   <= (row < ROWS_L);
      s1_cur_q    <= cursor_hit_d;
      // The phase travels with the pixel so a toggle only affects pixels
      // that enter the pipeline after the toggling edge.
      s1_ph_q     <= phase_q;
    end
  end

  assign o_char_addr = char_addr_q;

  // -------------------------------------------------------------------------
  // Stage 2 (E2)
  // -------------------------------------------------------------------------
  logic [11:0] font_addr_q;
  logic [2:0]  s2_xs_q;
  logic [3:0]  s2_fg_q;
  logic [2:0]  s2_bg_q;
  logic        s2_blink_q;
  logic        s2_act_q, s2_hs_q, s2_vs_q, s2_text_q, s2_cur_q, s2_ph_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      font_addr_q <= 12'd0;
      s2_xs_q     <= 3'd0;
      s2_fg_q     <= 4'd0;
      s2_bg_q     <= 3'd0;
      s2_blink_q  <= 1'b0;
      s2_act_q    <= 1'b0;
      s2_hs_q     <= 1'b1;
      s2_vs_q     <= 1'b1;
      s2_text_q   <= 1'b0;
      s2_cur_q    <= 1'b0;
      s2_ph_q     <= 1'b0;
    end else begin
      font_addr_q <= {i_char_data[7:0], s1_line_q};
      s2_xs_q     <= s1_xs_q;
      s2_fg_q     <= i_char_data[11:8];
      s2_bg_q     <= i_char_data[14:12];
      s2_blink_q  <= i_char_data[15];
      s2_act_q    <= s1_act_q;
      s2_hs_q     <= s1_hs_q;
      s2_vs_q     <= s1_vs_q;
      s2_text_q   <= s1_text_q;
      s2_cur_q    <= s1_cur_q;
      s2_ph_q     <= s1_ph_q;
    end
  end

  assign o_font_addr = font_addr_q;

  // -------------------------------------------------------------------------
  // Stage 3 (E3): pixel select, attributes, palette
  // -------------------------------------------------------------------------
  // Index {I,R,G,B}; index 6 is the classic brown instead of dark yellow.
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [3:0] hi, lo;
    hi = idx[3] ? 4'hF : 4'hA;
    lo = idx[3] ? 4'h5 : 4'h0;
    if (idx == 4'd6) palette = 12'hA50;
    else             palette = {idx[2] ? hi : lo, idx[1] ? hi : lo, idx[0] ? hi : lo};
  endfunction

  logic        pix_bit;
  logic [3:0]  color_idx;
  logic [11:0] rgb_d;

  always_comb begin
    pix_bit = i_font_data[3'd7 - s2_xs_q];
    if (s2_blink_q && !s2_ph_q) pix_bit = 1'b0;
    if (s2_cur_q && s2_ph_q)    pix_bit = 1'b1;
    color_idx = pix_bit ? s2_fg_q : {1'b0, s2_bg_q};
    rgb_d     = (s2_act_q && s2_text_q) ? palette(color_idx) : 12'h000;
  end

  logic [11:0] rgb_q;
  logic        hs_q, vs_q, act_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= s2_hs_q;
      vs_q  <= s2_vs_q;
      act_q <= s2_act_q;
    end
  end

  assign o_r      = rgb_q[11:8];
  assign o_g      = rgb_q[7:4];
  assign o_b      = rgb_q[3:0];
  assign o_hs     = hs_q;
  assign o_vs     = vs_q;
  assign o_active = act_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
module tb_vga_text_renderer;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] x;
  logic [10:0] y;
  logic        active, hs, vs, screenend;
  logic [7:0]  cursor_col;
  logic [6:0]  cursor_row;
  logic        cursor_en;
  logic [13:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  r, g, b;
  logic        o_hs, o_vs, o_act;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];

  vga_text_renderer #(
    .COLS(240), .ROWS(67), .BLINK_FRAMES(2), .CURSOR_FIRST_LINE(14)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_active(active),
    .i_hs(hs), .i_vs(vs), .i_screenend(screenend),
    .i_cursor_col(cursor_col), .i_cursor_row(cursor_row), .i_cursor_en(cursor_en),
    .o_char_addr(char_addr), .i_char_data(char_data),
    .o_font_addr(font_addr), .i_font_data(font_data),
    .o_r(r), .o_g(g), .o_b(b), .o_hs(o_hs), .o_vs(o_vs), .o_active(o_act)
  );

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_pixel(input logic [11:0] px, input logic [10:0] py,
                           input logic act, input logic [15:0] cd, input logic [7:0] fd);
    x = px; y = py; active = act; char_data = cd; font_data = fd;
  endtask

  task automatic pulse_screenend();
    screenend = 1'b1;
    step();
    screenend = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    set_pixel(12'd17, 11'd35, 1'b1, 16'h0F41, 8'hFF);
    hs = 1'b0; vs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({char_addr, font_addr, r, g, b, o_hs, o_vs, o_act} !== {14'd0, 12'd0, 12'h000, 3'b110}) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: addr=%0d font=%h rgb=%h hs=%b vs=%b act=%b, required 0/0/000/1/1/0",
                 i, char_addr, font_addr, {r, g, b}, o_hs, o_vs, o_act);
      end
    end
    rst = 1'b0;
    set_pixel(12'd0, 11'd0, 1'b0, 16'h0000, 8'h00);
    hs = 1'b1; vs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({r, g, b, o_hs, o_vs, o_act} !== {12'h000, 3'b110}) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: rgb=%h hs=%b vs=%b act=%b, required 000/1/1/0",
                 i, {r, g, b}, o_hs, o_vs, o_act);
      end
    end
  endtask

  task automatic test_char_pixel();
    set_pixel(12'd17, 11'd35, 1'b1, 16'h0F41, 8'h40);
    step();
    n_checks++;
    if (char_addr !== 14'd482) begin
      n_fail++; $display("FAIL char_addr: got %0d required 482", char_addr);
    end
    step();
    n_checks++;
    if (font_addr !== 12'h413) begin
      n_fail++; $display("FAIL font_addr: got %h required 413", font_addr);
    end
    n_checks++;
    if ({r, g, b, o_act} !== {12'h000, 1'b0}) begin
      n_fail++; $display("FAIL latency_early: rgb=%h act=%b required 000/0", {r, g, b}, o_act);
    end
    step();
    n_checks++;
    if ({r, g, b, o_act} !== {12'hFFF, 1'b1}) begin
      n_fail++; $display("FAIL fg_pixel: rgb=%h act=%b required FFF/1", {r, g, b}, o_act);
    end
  endtask

  task automatic test_bg_and_inactive();
    set_pixel(12'd16, 11'd35, 1'b1, 16'h1F41, 8'h40);
    steps(3);
    n_checks++;
    if ({r, g, b} !== 12'h00A) begin
      n_fail++; $display("FAIL bg_pixel: rgb=%h required 00A", {r, g, b});
    end
    active = 1'b0;
    steps(3);
    n_checks++;
    if ({r, g, b, o_act} !== {12'h000, 1'b0}) begin
      n_fail++; $display("FAIL inactive: rgb=%h act=%b required 000/0", {r, g, b}, o_act);
    end
  endtask

  task automatic test_brown();
    set_pixel(12'd8, 11'd0, 1'b1, 16'h0641, 8'hFF);
    steps(3);
    n_checks++;
    if ({r, g, b} !== 12'hA50) begin
      n_fail++; $display("FAIL brown: rgb=%h required A50", {r, g, b});
    end
    char_data = 16'h0C41;  // bright red
    steps(3);
    n_checks++;
    if ({r, g, b} !== 12'hF55) begin
      n_fail++; $display("FAIL bright_red: rgb=%h required F55", {r, g, b});
    end
  endtask

  task automatic test_bottom_lines();
    logic [11:0] xs [3];
    xs[0] = 12'd0; xs[1] = 12'd100; xs[2] = 12'd1919;
    for (int i = 0; i < 3; i++) begin
      set_pixel(xs[i], 11'd1075, 1'b1, 16'h7F41, 8'hFF);
      steps(3);
      n_checks++;
      if ({r, g, b, o_act} !== {12'h000, 1'b1}) begin
        n_fail++; $display("FAIL bottom_lines x=%0d: rgb=%h act=%b required 000/1", xs[i], {r, g, b}, o_act);
      end
    end
  endtask

  task automatic test_sync_delay();
    logic [19:0] hs_tbl, vs_tbl;
    logic [1:0]  e;
    hs_tbl = 20'b1011_0011_1000_1101_0110;
    vs_tbl = 20'b1100_1010_0111_0001_1011;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      hs = hs_tbl[i]; vs = vs_tbl[i];
      exp_q.push_back({hs, vs});
      step();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_hs, o_vs} !== e) begin
          n_fail++; $display("FAIL sync_delay i=%0d: got %b required %b", i, {o_hs, o_vs}, e);
        end
      end
    end
    hs = 1'b1; vs = 1'b1;
    steps(3);
  endtask

  task automatic test_mid_reset();
    set_pixel(12'd17, 11'd35, 1'b1, 16'h0F41, 8'h40);
    hs = 1'b0;
    steps(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hs = 1'b1;
    set_pixel(12'd0, 11'd0, 1'b0, 16'h0000, 8'h00);
    n_checks++;
    if ({r, g, b, o_hs, o_act} !== {12'h000, 2'b10}) begin
      n_fail++; $display("FAIL mid_reset: rgb=%h hs=%b act=%b required 000/1/0", {r, g, b}, o_hs, o_act);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({r, g, b, o_act} !== {12'h000, 1'b0}) begin
        n_fail++; $display("FAIL mid_reset_drain cyc %0d: rgb=%h act=%b required 000/0", i, {r, g, b}, o_act);
      end
    end
  endtask

  // Cursor at (5,3) on scanline 15, glyph empty, fg red, bg black.
  task automatic check_cursor(input logic [11:0] expv, input string tag);
    cursor_en = 1'b1;
    set_pixel(12'd42, 11'd63, 1'b1, 16'h0441, 8'h00);
    steps(3);
    n_checks++;
    if ({r, g, b} !== expv) begin
      n_fail++; $display("FAIL cursor_%s: rgb=%h required %h", tag, {r, g, b}, expv);
    end
  endtask

  // Blinking character, glyph full, fg white, bg green.
  task automatic check_blink_char(input logic [11:0] expv, input string tag);
    cursor_en = 1'b0;
    set_pixel(12'd42, 11'd63, 1'b1, 16'hAF41, 8'hFF);
    steps(3);
    n_checks++;
    if ({r, g, b} !== expv) begin
      n_fail++; $display("FAIL blink_char_%s: rgb=%h required %h", tag, {r, g, b}, expv);
    end
  endtask

  task automatic test_blink();
    cursor_col = 8'd5; cursor_row = 7'd3;
    check_cursor(12'h000, "phase0_start");
    check_blink_char(12'h0A0, "phase0_start");
    pulse_screenend();
    check_cursor(12'h000, "after_pulse1");
    pulse_screenend();
    check_cursor(12'hA00, "after_pulse2");
    check_blink_char(12'hFFF, "after_pulse2");
    // Scanline 13 is above the underline.
    cursor_en = 1'b1;
    set_pixel(12'd42, 11'd61, 1'b1, 16'h0441, 8'h00);
    steps(3);
    n_checks++;
    if ({r, g, b} !== 12'h000) begin
      n_fail++; $display("FAIL cursor_line13: rgb=%h required 000", {r, g, b});
    end
    // Neighbouring column is not the cursor.
    set_pixel(12'd50, 11'd63, 1'b1, 16'h0441, 8'h00);
    steps(3);
    n_checks++;
    if ({r, g, b} !== 12'h000) begin
      n_fail++; $display("FAIL cursor_col6: rgb=%h required 000", {r, g, b});
    end
    pulse_screenend();
    check_cursor(12'hA00, "after_pulse3");
    pulse_screenend();
    check_cursor(12'h000, "after_pulse4");
    check_blink_char(12'h0A0, "after_pulse4");
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b1; screenend = 1'b0;
    hs = 1'b1; vs = 1'b1;
    cursor_col = 8'd0; cursor_row = 7'd0; cursor_en = 1'b0;
    set_pixel(12'd0, 11'd0, 1'b0, 16'h0000, 8'h00);
    #1;
    test_reset();
    test_char_pixel();
    test_bg_and_inactive();
    test_brown();
    test_bottom_lines();
    test_sync_delay();
    test_mid_reset();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
